// File: rtl/tmr_sipo_receiver.sv
// Serial-in/parallel-out word receiver with triplicated shift register, bit counter
// and holding register; every replica reloads from the majority vote each cycle.
module tmr_sipo_receiver #(
   parameter int width = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             serial_in,
   input  logic             bit_valid,
   input  logic             msb_first,
   output logic [width-1:0] parallel_out,
   output logic             word_valid,
   input  logic             word_ready,
   output logic             overrun,
   input  logic             clear_status,
   input  logic [2:0]       fault_inject,
   output logic [2:0]       fault_flags,
   output logic [7:0]       fault_count
);

   localparam int CW = (width > 1) ? $clog2(width) : 1;
   localparam logic [CW-1:0] LAST = CW'(width - 1);

   logic [width-1:0] sr   [3];
   logic [CW-1:0]    cnt  [3];
   logic [width-1:0] hold [3];

   logic [width-1:0] sr_v, hold_v, sr_next, hold_next;
   logic [CW-1:0]    cnt_v, cnt_next;
   logic             accept, complete, take, drop;
   logic             wv_q, ovr_q;
   logic [7:0]       fcnt_q;
   logic             fault_any;

   // Bitwise majority of the three copies.
   assign sr_v   = (sr[0] & sr[1]) | (sr[0] & sr[2]) | (sr[1] & sr[2]);
   assign cnt_v  = (cnt[0] & cnt[1]) | (cnt[0] & cnt[2]) | (cnt[1] & cnt[2]);
   assign hold_v = (hold[0] & hold[1]) | (hold[0] & hold[2]) | (hold[1] & hold[2]);

   assign accept   = enable & bit_valid;
   assign complete = accept & (cnt_v == LAST);
   assign take     = complete & (~wv_q | word_ready);
   assign drop     = complete & wv_q & ~word_ready;

   always_comb begin
      sr_next  = sr_v;
      cnt_next = cnt_v;
      if (accept) begin
         if (msb_first) sr_next = {sr_v[width-2:0], serial_in};
         else           sr_next = {serial_in, sr_v[width-1:1]};
         cnt_next = (cnt_v == LAST) ? '0 : cnt_v + 1'b1;
      end
   end

   assign hold_next = take ? sr_next : hold_v;

   // Replicas never feed back their own value, so a single upset is scrubbed next edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 3; i++) begin
            sr[i]   <= '0;
            cnt[i]  <= '0;
            hold[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 3; i++) begin
            sr[i]   <= sr_next ^ {{(width-1){1'b0}}, fault_inject[i]};
            cnt[i]  <= cnt_next;
            hold[i] <= hold_next;
         end
      end
   end

   always_comb begin
      fault_flags = '0;
      for (int i = 0; i < 3; i++)
         fault_flags[i] = (sr[i] != sr_v) | (cnt[i] != cnt_v) | (hold[i] != hold_v);
   end

   assign fault_any = |fault_flags;

   // A set or increment in the same cycle as clear_status takes priority over the clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wv_q   <= 1'b0;
         ovr_q  <= 1'b0;
         fcnt_q <= '0;
      end else begin
         if (take)            wv_q <= 1'b1;
         else if (word_ready) wv_q <= 1'b0;

         if (drop)              ovr_q <= 1'b1;
         else if (clear_status) ovr_q <= 1'b0;

         if (fault_any) begin
            if (clear_status)         fcnt_q <= 8'd1;
            else if (fcnt_q != 8'hff) fcnt_q <= fcnt_q + 8'd1;
         end else if (clear_status) begin
            fcnt_q <= '0;
         end
      end
   end

   assign parallel_out = hold_v;
   assign word_valid   = wv_q;
   assign overrun      = ovr_q;
   assign fault_count  = fcnt_q;

endmodule

// File: doc/tmr_sipo_receiver.md
# tmr_sipo_receiver

Serial-in/parallel-out receiver that reassembles words from the one-bit stream produced by the triple-modular-redundant shift-register transmitter. The shift register, bit counter and output holding register are each triplicated, majority-voted and scrubbed every cycle. Completed words are presented on a valid/ready interface. An overrun flag reports words lost because of backpressure, and per-replica fault flags report any disagreement among the three copies.

## Interface
- width, 16: word length in bits (≥ 2); bit counter is $clog2(width) bits
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- enable  input  1  bit acceptance enable
- serial_in  input  1  serial data bit
- bit_valid  input  1  serial_in carries a bit this cycle
- msb_first  input  1  0: first received bit lands in bit 0; 1: first bit lands in bit width-1
- parallel_out  output  width  voted output holding register
- word_valid  output  1  parallel_out holds an unconsumed word
- word_ready  input  1  consumer accepts the word
- overrun  output  1  sticky: a completed word was dropped
- clear_status  input  1  synchronous clear of overrun and fault_count
- fault_inject  input  3  test hook: bit i corrupts replica i
- fault_flags  output  3  bit i: replica i disagrees with the vote
- fault_count  output  8  saturating count of cycles with any fault flag set

## Operation
- **Replicas.** Three copies each of:
  - shift register sr[i]
  - bit counter cnt[i]
  - holding register hold[i]
- **Voting.** Each replica's next state is computed from the bitwise-majority voted value, never from its own value. This scrubs a single upset on the next edge. word_valid and overrun are single flops.
- **Accept condition.** A bit is accepted when enable & bit_valid.
  - msb_first=0: sr_next = {serial_in, sr_v[width-1:1]} (shift right).
  - msb_first=1: sr_next = {sr_v[width-2:0], serial_in} (shift left).
  - msb_first is applied per accepted bit and must be held stable for the whole word.
- **Counter.** On accept, cnt_next = cnt_v + 1. When cnt_v == width-1, cnt_next = 0 and the word completes.
- **Word completion.** The assembled word is sr_next.
  - word_valid=0, or word_valid=1 with word_ready=1: hold ← word, word_valid=1.
  - word_valid=1 with word_ready=0: the word is dropped, hold is unchanged and overrun sets.
  - The shift register keeps accepting the next word with no gap (double buffering).
- **Handshake.** Transfer occurs on word_valid & word_ready. With no completion in the same cycle, word_valid clears next cycle. Holding register data stays stable while word_valid=1 and word_ready=0.
- **Fault detection.**
  - fault_flags[i] (combinational) = (sr[i] != sr_v) | (cnt[i] != cnt_v) | (hold[i] != hold_v).
  - fault_count increments once per cycle with |fault_flags and saturates at 255.
- **Fault injection.** fault_inject[i] high at an edge XORs bit 0 of replica i's sr next value.
- **clear_status.** Zeroes overrun and fault_count. A simultaneous set or increment wins over the clear, leaving overrun=1 and fault_count=1.
- **enable=0.** No bits are accepted and the counter freezes. The output handshake, scrubbing and status logic keep running.

## Timing
- Reset (rst=0, asynchronous): all replicas, word_valid, overrun and fault_count go to 0. Consequently parallel_out=0, word_valid=0, overrun=0, fault_flags=0 and fault_count=0.
- A reset mid-word discards the partial word. The first bit after reset release is bit 1 of a new word.
- Latency: word_valid rises on the edge that accepts the width-th bit, so it is visible the following cycle.
- Maximum throughput is one bit per cycle. At that rate word_ready must be high at least once per width cycles to avoid overrun.
- Fault injection sequence:
  - fault_flags[i] goes high in the cycle after the inject edge.
  - It clears after the next edge (scrub).
  - fault_count therefore increments by exactly 1 per single-replica injection.
- A single-replica fault never alters parallel_out, word_valid or the received data.

## Test plan
- **LSB-first word.** width=16, msb_first=0, send 0xA5C3 LSB first over 16 consecutive cycles with word_ready=0. Required: word_valid=1 one cycle after the 16th bit, parallel_out=0xA5C3, data held until word_ready=1, word_valid=0 the cycle after transfer.
- **MSB-first back-to-back.** msb_first=1, send 0x1234 MSB first, then 0xBEEF with no gap, word_ready=1 throughout. Required: two words 0x1234 then 0xBEEF, overrun=0.
- **Overrun.** Send three words with word_ready=0. Required: parallel_out keeps the first word, overrun=1 after the second completes. After clear_status pulse: overrun=0.
- **Gapped input.** Toggle enable and bit_valid randomly mid-word. Required: the counter holds and the word is still correct.
- **Fault injection and scrub.** Pulse fault_inject=3'b010 mid-word. Required: fault_flags=3'b010 for exactly 1 cycle, fault_count=1, received word correct. Repeat for each replica, including on the completion cycle.
- **Reset mid-word.** Assert rst after 7 bits. Required: all outputs 0 immediately. A fresh 16-bit word is then received correctly.
